// File: rtl/ethernet_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : ethernet_transmitter
// Purpose  : Ethernet II TX framer; arbitrates IP/ARP streams, prepends the
//            14-byte header, pads runts to the minimum and truncates giants.
// Revision : 1.0
// ============================================================================
module ethernet_transmitter #(
    parameter int          DATA_WIDTH      = 8,
    parameter int          MIN_FRAME_BYTES = 60,
    parameter int          MAX_FRAME_BYTES = 1514,
    parameter logic [15:0] ARP_HEADER_TYPE = 16'h0806,
    parameter logic [15:0] IP_HEADER_TYPE  = 16'h0800
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ip_tx_tvalid,
    input  logic [DATA_WIDTH-1:0] ip_tx_tdata,
    input  logic                  ip_tx_tlast,
    output logic                  ip_tx_tready,
    input  logic [47:0]           ip_tx_dest_mac,
    input  logic                  arp_tx_tvalid,
    input  logic [DATA_WIDTH-1:0] arp_tx_tdata,
    input  logic                  arp_tx_tlast,
    output logic                  arp_tx_tready,
    input  logic [47:0]           arp_tx_dest_mac,
    input  logic [47:0]           temac_address,
    output logic                  temac_tx_tvalid,
    output logic [DATA_WIDTH-1:0] temac_tx_tdata,
    output logic                  temac_tx_tlast,
    output logic                  temac_tx_tuser,
    input  logic                  temac_tx_tready,
    output logic                  tx_busy,
    output logic [15:0]           frames_sent,
    output logic [15:0]           frames_truncated
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_PAD     = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    localparam logic [10:0] c_LAST_HEADER_BYTE = 11'd13;
    localparam logic [10:0] c_MIN_LAST_BYTE    = 11'(MIN_FRAME_BYTES - 1);
    localparam logic [10:0] c_MAX_LAST_BYTE    = 11'(MAX_FRAME_BYTES - 1);
    localparam logic [11:0] c_MIN_BYTES        = 12'(MIN_FRAME_BYTES);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_grant_arp;
    logic                    r_last_grant_arp;
    logic [111:0]            r_header;
    logic [10:0]             r_byte_count;
    logic [15:0]             r_frames_sent;
    logic [15:0]             r_frames_truncated;

    logic                    w_src_tvalid;
    logic [DATA_WIDTH-1:0]   w_src_tdata;
    logic                    w_src_tlast;
    logic                    w_src_ready;
    logic                    w_handshake;
    logic                    w_tie;
    logic                    w_pick_arp;
    logic                    w_reached_min;
    logic                    w_at_max;

    assign w_src_tvalid  = r_grant_arp ? arp_tx_tvalid : ip_tx_tvalid;
    assign w_src_tdata   = r_grant_arp ? arp_tx_tdata  : ip_tx_tdata;
    assign w_src_tlast   = r_grant_arp ? arp_tx_tlast  : ip_tx_tlast;
    assign w_handshake   = temac_tx_tvalid && temac_tx_tready;
    assign w_tie         = ip_tx_tvalid && arp_tx_tvalid;
    // Round-robin memory only moves on contested grants, so a tie after an
    // ARP-won tie goes to IP even if IP was later granted uncontested.
    assign w_pick_arp    = arp_tx_tvalid && (!ip_tx_tvalid || !r_last_grant_arp);
    assign w_reached_min = ({1'b0, r_byte_count} + 12'd1) >= c_MIN_BYTES;
    assign w_at_max      = (r_byte_count == c_MAX_LAST_BYTE);

    assign ip_tx_tready     = w_src_ready && !r_grant_arp;
    assign arp_tx_tready    = w_src_ready && r_grant_arp;
    assign tx_busy          = (r_state != S_IDLE);
    assign frames_sent      = r_frames_sent;
    assign frames_truncated = r_frames_truncated;

    always_comb begin
        w_next_state    = r_state;
        temac_tx_tvalid = 1'b0;
        temac_tx_tdata  = '0;
        temac_tx_tlast  = 1'b0;
        temac_tx_tuser  = 1'b0;
        w_src_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ip_tx_tvalid || arp_tx_tvalid)
                    w_next_state = S_HEADER;
            end
            S_HEADER: begin
                temac_tx_tvalid = 1'b1;
                temac_tx_tdata  = r_header[111:104];
                if (w_handshake && (r_byte_count == c_LAST_HEADER_BYTE))
                    w_next_state = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                temac_tx_tvalid = w_src_tvalid;
                temac_tx_tdata  = w_src_tdata;
                w_src_ready     = temac_tx_tready;
                if (w_src_tvalid) begin
                    if (w_src_tlast) begin
                        temac_tx_tlast = w_reached_min;
                    end else if (w_at_max) begin
                        temac_tx_tlast = 1'b1;
                        temac_tx_tuser = 1'b1;
                    end
                end
                if (w_handshake) begin
                    if (w_src_tlast)
                        w_next_state = w_reached_min ? S_IDLE : S_PAD;
                    else if (w_at_max)
                        w_next_state = S_DRAIN;
                end
            end
            S_PAD: begin
                temac_tx_tvalid = 1'b1;
                temac_tx_tlast  = (r_byte_count == c_MIN_LAST_BYTE);
                if (w_handshake && temac_tx_tlast)
                    w_next_state = S_IDLE;
            end
            S_DRAIN: begin
                w_src_ready = 1'b1;
                if (w_src_tvalid && w_src_tlast)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_grant_arp        <= 1'b0;
            r_last_grant_arp   <= 1'b0;
            r_header           <= '0;
            r_byte_count       <= '0;
            r_frames_sent      <= '0;
            r_frames_truncated <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (ip_tx_tvalid || arp_tx_tvalid) begin
                        r_grant_arp  <= w_pick_arp;
                        r_byte_count <= '0;
                        r_header     <= w_pick_arp
                            ? {arp_tx_dest_mac, temac_address, ARP_HEADER_TYPE}
                            : {ip_tx_dest_mac,  temac_address, IP_HEADER_TYPE};
                        if (w_tie)
                            r_last_grant_arp <= w_pick_arp;
                    end
                end
                S_HEADER: begin
                    if (w_handshake) begin
                        r_byte_count <= r_byte_count + 11'd1;
                        r_header     <= {r_header[103:0], 8'h00};
                    end
                end
                S_PAYLOAD: begin
                    if (w_handshake) begin
                        r_byte_count <= r_byte_count + 11'd1;
                        if (w_src_tlast && w_reached_min)
                            r_frames_sent <= r_frames_sent + 16'd1;
                        else if (!w_src_tlast && w_at_max)
                            r_frames_truncated <= r_frames_truncated + 16'd1;
                    end
                end
                S_PAD: begin
                    if (w_handshake) begin
                        r_byte_count <= r_byte_count + 11'd1;
                        if (temac_tx_tlast)
                            r_frames_sent <= r_frames_sent + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ethernet_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ethernet_transmitter
// Purpose  : Self-checking bench: table vectors, directed corner sequences and
//            randomized frames scored against a frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_ethernet_transmitter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ip_tx_tvalid = 1'b0, ip_tx_tlast = 1'b0;
    logic [7:0]  ip_tx_tdata = '0;
    logic        ip_tx_tready;
    logic [47:0] ip_tx_dest_mac = '0;
    logic        arp_tx_tvalid = 1'b0, arp_tx_tlast = 1'b0;
    logic [7:0]  arp_tx_tdata = '0;
    logic        arp_tx_tready;
    logic [47:0] arp_tx_dest_mac = '0;
    logic [47:0] temac_address = 48'h000A35010203;
    logic        temac_tx_tvalid, temac_tx_tlast, temac_tx_tuser;
    logic [7:0]  temac_tx_tdata;
    logic        temac_tx_tready = 1'b1;
    logic        tx_busy;
    logic [15:0] frames_sent, frames_truncated;

    always #5 clock = ~clock;

    ethernet_transmitter dut (
        .clock(clock), .reset(reset),
        .ip_tx_tvalid(ip_tx_tvalid), .ip_tx_tdata(ip_tx_tdata), .ip_tx_tlast(ip_tx_tlast),
        .ip_tx_tready(ip_tx_tready), .ip_tx_dest_mac(ip_tx_dest_mac),
        .arp_tx_tvalid(arp_tx_tvalid), .arp_tx_tdata(arp_tx_tdata), .arp_tx_tlast(arp_tx_tlast),
        .arp_tx_tready(arp_tx_tready), .arp_tx_dest_mac(arp_tx_dest_mac),
        .temac_address(temac_address),
        .temac_tx_tvalid(temac_tx_tvalid), .temac_tx_tdata(temac_tx_tdata),
        .temac_tx_tlast(temac_tx_tlast), .temac_tx_tuser(temac_tx_tuser),
        .temac_tx_tready(temac_tx_tready),
        .tx_busy(tx_busy), .frames_sent(frames_sent), .frames_truncated(frames_truncated)
    );

    typedef struct {
        bit          arp;
        int          len;
        logic [47:0] dest;
        bit          bp;
        int          out_len;
        bit          user;
    } vec_t;

    vec_t         vecs[11];
    int           checks = 0, errors = 0;
    int           stall_viol = 0, user_viol = 0;
    bit           bp_mode = 1'b0, abort = 1'b0;
    byte unsigned ip_pl[$], arp_pl[$];
    byte unsigned cur[$], rx_bytes[$], exp_bytes[$];
    int           rx_len[$], exp_len[$];
    bit           rx_user[$], exp_user[$];
    int           model_sent = 0, model_trunc = 0;
    bit           last_tie_arp = 1'b0;

    logic         prev_stall = 1'b0, prev_last = 1'b0, prev_user = 1'b0;
    logic [7:0]   prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clock);
        #1;
        temac_tx_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Collects delivered frames and watches AXIS stability while stalled.
    always @(negedge clock) begin
        if (!tx_busy) cur.delete();
        if (prev_stall && (!temac_tx_tvalid || temac_tx_tdata !== prev_data ||
                           temac_tx_tlast !== prev_last || temac_tx_tuser !== prev_user))
            stall_viol++;
        if (temac_tx_tvalid && temac_tx_tuser && !temac_tx_tlast) user_viol++;
        if (!reset && temac_tx_tvalid && temac_tx_tready) begin
            cur.push_back(temac_tx_tdata);
            if (temac_tx_tlast) begin
                foreach (cur[k]) rx_bytes.push_back(cur[k]);
                rx_len.push_back(cur.size());
                rx_user.push_back(temac_tx_tuser);
                cur.delete();
            end
        end
        prev_stall = !reset && temac_tx_tvalid && !temac_tx_tready;
        prev_data  = temac_tx_tdata;
        prev_last  = temac_tx_tlast;
        prev_user  = temac_tx_tuser;
    end

    task automatic fill_pl(input bit arp, input int len);
        if (arp) arp_pl.delete(); else ip_pl.delete();
        for (int k = 0; k < len; k++) begin
            if (arp) arp_pl.push_back(8'($urandom_range(0, 255)));
            else     ip_pl.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    // Reference frame: header + payload, zero-padded to 60, cut at 1514.
    task automatic expect_frame(input bit arp, input logic [47:0] dest);
        byte unsigned f[$];
        logic [15:0]  et;
        int           n;
        et = arp ? 16'h0806 : 16'h0800;
        for (int k = 0; k < 6; k++) f.push_back(dest[47-8*k -: 8]);
        for (int k = 0; k < 6; k++) f.push_back(temac_address[47-8*k -: 8]);
        f.push_back(et[15:8]);
        f.push_back(et[7:0]);
        if (arp) foreach (arp_pl[k]) f.push_back(arp_pl[k]);
        else     foreach (ip_pl[k])  f.push_back(ip_pl[k]);
        while (f.size() < 60) f.push_back(8'h00);
        n = (f.size() > 1514) ? 1514 : f.size();
        for (int k = 0; k < n; k++) exp_bytes.push_back(f[k]);
        exp_len.push_back(n);
        exp_user.push_back(f.size() > 1514);
        if (f.size() > 1514) model_trunc++; else model_sent++;
    endtask

    task automatic send_src(input bit arp, input logic [47:0] dest, input bit gaps);
        int n, i, cyc;
        bit v, r;
        n = arp ? arp_pl.size() : ip_pl.size();
        i = 0; cyc = 0; v = 1'b0;
        @(posedge clock);
        #1;
        if (arp) arp_tx_dest_mac = dest; else ip_tx_dest_mac = dest;
        while (i < n && !abort) begin
            if (!v) v = (i == 0) || !gaps || ($urandom_range(0, 3) != 0);
            if (arp) begin
                arp_tx_tvalid = v; arp_tx_tdata = arp_pl[i]; arp_tx_tlast = (i == n - 1);
            end else begin
                ip_tx_tvalid = v; ip_tx_tdata = ip_pl[i]; ip_tx_tlast = (i == n - 1);
            end
            @(negedge clock);
            r = arp ? arp_tx_tready : ip_tx_tready;
            @(posedge clock);
            #1;
            if (v && r) begin i++; v = 1'b0; end
            cyc++;
            if (cyc > 12000) begin
                checks++; errors++;
                $display("FAIL source_timeout arp=%0d: accepted %0d of %0d bytes", arp, i, n);
                break;
            end
        end
        if (arp) begin arp_tx_tvalid = 1'b0; arp_tx_tlast = 1'b0; arp_tx_tdata = '0; end
        else     begin ip_tx_tvalid  = 1'b0; ip_tx_tlast  = 1'b0; ip_tx_tdata  = '0; end
    endtask

    task automatic wait_frames(input int n);
        int c;
        c = 0;
        while (rx_len.size() < n && c < 4000) begin @(negedge clock); c++; end
        check("frame_arrival", 64'(rx_len.size() >= n), 64'd1);
    endtask

    task automatic compare_one(input string tag, input int tl, input bit tu, input bit use_tbl);
        int el, rl, bad, m;
        bit eu, ru;
        byte unsigned a, e;
        el = exp_len.pop_front();
        eu = exp_user.pop_front();
        if (rx_len.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_missing: no frame received, required length %0d", tag, el);
            repeat (el) void'(exp_bytes.pop_front());
            return;
        end
        rl = rx_len.pop_front();
        ru = rx_user.pop_front();
        check({tag, "_len"},   64'(rl), use_tbl ? 64'(tl) : 64'(el));
        check({tag, "_tuser"}, 64'(ru), use_tbl ? 64'(tu) : 64'(eu));
        bad = 0;
        m = (el > rl) ? el : rl;
        for (int k = 0; k < m; k++) begin
            a = (k < rl) ? rx_bytes.pop_front() : 8'h00;
            e = (k < el) ? exp_bytes.pop_front() : 8'h00;
            if (k >= rl || k >= el || a != e) bad++;
        end
        check({tag, "_bad_bytes"}, 64'(bad), 64'd0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frames_sent"},      64'(frames_sent),      64'(16'(model_sent)));
        check({tag, "_frames_truncated"}, 64'(frames_truncated), 64'(16'(model_trunc)));
    endtask

    // Both sources raise tvalid together; the round-robin winner goes first.
    task automatic do_tie(input string tag, input int la, input int li, input bit gaps);
        logic [47:0] da, di;
        bit win_arp;
        da = {16'($urandom), $urandom};
        di = {16'($urandom), $urandom};
        fill_pl(1'b1, la);
        fill_pl(1'b0, li);
        win_arp = !last_tie_arp;
        last_tie_arp = win_arp;
        expect_frame(win_arp, win_arp ? da : di);
        expect_frame(!win_arp, win_arp ? di : da);
        fork
            send_src(1'b1, da, gaps);
            send_src(1'b0, di, gaps);
        join
        wait_frames(2);
        compare_one({tag, "_first"},  0, 1'b0, 1'b0);
        compare_one({tag, "_second"}, 0, 1'b0, 1'b0);
        check_counters(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{arp: 1'b1, len: 28,   dest: 48'hFFFFFFFFFFFF, bp: 1'b0, out_len: 60,   user: 1'b0};
        vecs[1]  = '{arp: 1'b0, len: 100,  dest: 48'h112233445566, bp: 1'b0, out_len: 114,  user: 1'b0};
        vecs[2]  = '{arp: 1'b0, len: 64,   dest: 48'hA0B0C0D0E0F0, bp: 1'b1, out_len: 78,   user: 1'b0};
        vecs[3]  = '{arp: 1'b0, len: 46,   dest: 48'h020000000001, bp: 1'b0, out_len: 60,   user: 1'b0};
        vecs[4]  = '{arp: 1'b0, len: 45,   dest: 48'h020000000002, bp: 1'b1, out_len: 60,   user: 1'b0};
        vecs[5]  = '{arp: 1'b0, len: 47,   dest: 48'h020000000003, bp: 1'b0, out_len: 61,   user: 1'b0};
        vecs[6]  = '{arp: 1'b1, len: 1,    dest: 48'h020000000004, bp: 1'b1, out_len: 60,   user: 1'b0};
        vecs[7]  = '{arp: 1'b0, len: 1500, dest: 48'h020000000005, bp: 1'b0, out_len: 1514, user: 1'b0};
        vecs[8]  = '{arp: 1'b0, len: 1501, dest: 48'h020000000006, bp: 1'b0, out_len: 1514, user: 1'b1};
        vecs[9]  = '{arp: 1'b0, len: 1600, dest: 48'h020000000007, bp: 1'b0, out_len: 1514, user: 1'b1};
        vecs[10] = '{arp: 1'b1, len: 1600, dest: 48'h020000000008, bp: 1'b1, out_len: 1514, user: 1'b1};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_tvalid",  64'(temac_tx_tvalid), 64'd0);
        check("rst_tdata",   64'(temac_tx_tdata),  64'd0);
        check("rst_tlast",   64'(temac_tx_tlast),  64'd0);
        check("rst_tuser",   64'(temac_tx_tuser),  64'd0);
        check("rst_ip_rdy",  64'(ip_tx_tready),    64'd0);
        check("rst_arp_rdy", 64'(arp_tx_tready),   64'd0);
        check("rst_busy",    64'(tx_busy),         64'd0);
        check_counters("rst");
        @(posedge clock);
        #1 reset = 1'b0;

        for (int v = 0; v < 11; v++) begin
            fill_pl(vecs[v].arp, vecs[v].len);
            expect_frame(vecs[v].arp, vecs[v].dest);
            bp_mode = vecs[v].bp;
            send_src(vecs[v].arp, vecs[v].dest, vecs[v].bp);
            bp_mode = 1'b0;
            wait_frames(1);
            if (v == 0 && rx_bytes.size() >= 60) begin
                check("arp_byte0",  64'(rx_bytes[0]),  64'hFF);
                check("arp_byte6",  64'(rx_bytes[6]),  64'h00);
                check("arp_byte8",  64'(rx_bytes[8]),  64'h35);
                check("arp_byte11", 64'(rx_bytes[11]), 64'h03);
                check("arp_byte12", 64'(rx_bytes[12]), 64'h08);
                check("arp_byte13", 64'(rx_bytes[13]), 64'h06);
                check("arp_byte59", 64'(rx_bytes[59]), 64'h00);
            end
            compare_one($sformatf("vec%0d", v), vecs[v].out_len, vecs[v].user, 1'b1);
            check_counters($sformatf("vec%0d", v));
        end

        do_tie("tie1", 40, 70, 1'b0);
        do_tie("tie2", 30, 55, 1'b0);

        // Reset lands while header byte 7 is on the bus.
        fill_pl(1'b0, 80);
        fork
            send_src(1'b0, 48'h0203040506A7, 1'b0);
            begin
                int c;
                c = 0;
                while (!temac_tx_tvalid && c < 50) begin @(negedge clock); c++; end
                repeat (7) @(negedge clock);
                check("mid_hdr_byte7", 64'(temac_tx_tdata), 64'(temac_address[39:32]));
                reset = 1'b1;
                abort = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                check("mid_rst_tvalid", 64'(temac_tx_tvalid), 64'd0);
                check("mid_rst_tlast",  64'(temac_tx_tlast),  64'd0);
                check("mid_rst_busy",   64'(tx_busy),         64'd0);
                model_sent = 0;
                model_trunc = 0;
                last_tie_arp = 1'b0;
                check_counters("mid_rst");
            end
        join
        abort = 1'b0;
        check("mid_rst_no_frame", 64'(rx_len.size()), 64'd0);
        fill_pl(1'b1, 28);
        expect_frame(1'b1, 48'hFFFFFFFFFFFF);
        send_src(1'b1, 48'hFFFFFFFFFFFF, 1'b0);
        wait_frames(1);
        compare_one("post_rst_arp", 0, 1'b0, 1'b0);
        check_counters("post_rst_arp");

        bp_mode = 1'b1;
        for (int it = 0; it < 16; it++) begin
            int  len;
            bit  arp, gaps;
            logic [47:0] dest;
            len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1400, 1600))
                                               : int'($urandom_range(1, 130));
            gaps = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                do_tie($sformatf("rnd%0d_tie", it), len, int'($urandom_range(1, 90)), gaps);
            end else begin
                arp  = 1'($urandom_range(0, 1));
                dest = {16'($urandom), $urandom};
                fill_pl(arp, len);
                expect_frame(arp, dest);
                fork
                    send_src(arp, dest, gaps);
                    begin
                        repeat (3) @(posedge clock);
                        #1 temac_address = {16'($urandom), $urandom};
                    end
                join
                wait_frames(1);
                compare_one($sformatf("rnd%0d", it), 0, 1'b0, 1'b0);
                check_counters($sformatf("rnd%0d", it));
            end
        end
        bp_mode = 1'b0;

        check("stall_stability_violations", 64'(stall_viol), 64'd0);
        check("tuser_off_tlast_violations", 64'(user_viol),  64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
